clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Bank of `NUM_CH` independent programmable clock dividers, each driven from the single system clock. It is the parametrised successor to the fixed single-output divider used for audio and display timing. Each channel produces:
- a 50 %-duty divided clock level,
- a one-cycle tick strobe at every toggle,
- a runtime-loadable half-period, applied glitch-free at the next half-period boundary.

## Interface
Parameters:
- `NUM_CH`, default 4: number of divider channels (1..16).
- `WIDTH`, default 18: width of the half-period value and of each channel counter.
- `DEFAULT_HALF`, default 250001: half-period loaded into every channel at reset (must fit in `WIDTH`).
- `CH_W`, default `max(1, clog2(NUM_CH))`: width of the channel select.

Ports:
- `clk_i` input, 1 bit: system clock. The block has this single clock.
- `rst_i` input, 1 bit: reset. Synchronous and active-high.
- `en_i` input, `NUM_CH` bits: per-channel run enable.
- `load_i` input, 1 bit: one-cycle request to write `half_i` into channel `ch_i`.
- `ch_i` input, `CH_W` bits: target channel for the load.
- `half_i` input, `WIDTH` bits: new half-period in `clk_i` cycles. 0 means stop the channel.
- `clk_o` output, `NUM_CH` bits: divided clock levels.
- `tick_o` output, `NUM_CH` bits: one-cycle strobe asserted on the cycle `clk_o[n]` changes.
- `pending_o` output, `NUM_CH` bits: a loaded value is waiting for the next boundary.
- `load_err_o` output, 1 bit: one-cycle pulse when a load targets `ch_i >= NUM_CH`.

## Operation
Per-channel state: `cnt` (`WIDTH` bits), `active` (half-period in use), `shadow` (loaded value), `pend`, `clk_o`, `tick_o`.

Reset, while `rst_i` is high at a clock edge:
- `cnt` = 0, `active` = `shadow` = `DEFAULT_HALF`, `pend` = 0.
- `clk_o` = 0, `tick_o` = 0, `load_err_o` = 0.
- Reset overrides every other input.

Running condition: `active != 0` and `en_i[n]` = 1. A running channel has two cases:
- Terminal, when `cnt >= active-1`:
  - `cnt` <= 0, `tick_o[n]` <= 1.
  - If `pend` = 1: `active` <= `shadow` and `pend` <= 0. If the new `active` is 0, `clk_o[n]` <= 0; otherwise `clk_o[n]` toggles.
  - If `pend` = 0: `clk_o[n]` toggles.
- Non-terminal: `cnt` <= `cnt`+1, `tick_o[n]` <= 0.

Disabled channel (`en_i[n]` = 0, `active != 0`):
- `cnt`, `clk_o[n]`, `active` and `pend` hold.
- `tick_o[n]` = 0.
- Re-enabling resumes mid-period from the held count.

Stopped channel (`active` = 0):
- `cnt` = 0, `clk_o[n]` = 0, `tick_o[n]` = 0.
- A pending nonzero `shadow` is applied on the next edge regardless of `en_i`: `active` <= `shadow`, `pend` <= 0, and counting starts from 0.

Load, when `load_i` = 1 and `ch_i < NUM_CH`:
- `shadow[ch_i]` <= `half_i`, `pend[ch_i]` <= 1.
- A load to a channel whose `pend` is already 1 overwrites `shadow`; only the last value is applied.
- A load on the same edge as that channel's terminal count does not take effect at that boundary. The old `shadow`/`pend` state is used at that edge, the new value is captured, `pend` stays 1, and the new value is applied at the following boundary.

Invalid load, when `load_i` = 1 and `ch_i >= NUM_CH`:
- No state changes.
- `load_err_o` <= 1 for one cycle.

Half-period 1 gives `clk_o` = `clk_i`/2. In general, output period = 2·`active` cycles, duty 50 %.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- From reset release, with `en_i[n]` = 1 and `active` = N: the first `clk_o[n]` rise follows the N-th rising edge after the edge where `rst_i` is sampled low. `tick_o[n]` is high in that same cycle.
- Load latency: `pending_o` is high from the edge after `load_i`.
- A new value takes effect at the first terminal edge strictly after the load edge. The worst case is `active` + 1 cycles with the channel enabled.
- `load_err_o` is high for exactly the cycle after the invalid request.

## Test plan
1. Reset, `en_i` = all 1, `DEFAULT_HALF` overridden to 3 → every `clk_o` rises after edge 3, falls after edge 6; `tick_o` pulses at edges 3, 6, 9…
2. Load `ch_i` = 1, `half_i` = 1 in mid-period of a half-period 3 → `pending_o[1]` = 1 until the current half completes, then `clk_o[1]` toggles every cycle; the other channels are unchanged.
3. Load on the same edge as channel 0's terminal count (3→5) → that boundary keeps the old value; the next half lasts 3 cycles; the half after that lasts 5 cycles.
4. Drop `en_i[2]` for 4 cycles when `cnt` = 1 (half = 3) → `clk_o[2]` and `cnt` hold; after re-enable, the toggle occurs 2 enabled cycles later; no tick while disabled.
5. Load `half_i` = 0 to channel 3, then later load 2 → at the boundary `clk_o[3]` goes to 0 and stays there; the nonzero load is applied on the next edge, and `clk_o[3]` rises 2 cycles after that.
6. With `NUM_CH` = 3, load `ch_i` = 3 → `load_err_o` pulses once; all `pending_o` stay 0.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of NUM_CH independent programmable clock dividers,
// all driven from the single system clock clk_i.
//
// Each channel makes a 50 %-duty divided clock level, a one-cycle tick strobe
// on every boundary, and a pending indicator. A half-period written by a load
// waits in a shadow register and is only applied at a half-period boundary,
// so the divided clock never glitches.
//
// Ports:
//   clk_i      - system clock
//   rst_i      - synchronous active-high reset
//   en_i       - per-channel run enable
//   load_i     - one-cycle request to write half_i into channel ch_i
//   ch_i       - target channel of a load
//   half_i     - new half-period in clk_i cycles (0 stops the channel)
//   clk_o      - divided clock levels
//   tick_o     - one-cycle strobe on each channel boundary
//   pending_o  - a loaded value is waiting for the next boundary
//   load_err_o - one-cycle pulse after a load that targets a missing channel
module clk_div_bank #(
   parameter int NUM_CH       = 4,
   parameter int WIDTH        = 18,
   parameter int DEFAULT_HALF = 250001,
   parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] en_i,
   input  logic              load_i,
   input  logic [CH_W-1:0]   ch_i,
   input  logic [WIDTH-1:0]  half_i,
   output logic [NUM_CH-1:0] clk_o,
   output logic [NUM_CH-1:0] tick_o,
   output logic [NUM_CH-1:0] pending_o,
   output logic              load_err_o
);

   // A load addressed past the last channel changes nothing except this flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         load_err_o <= 1'b0;
      end else begin
         load_err_o <= load_i && (int'(ch_i) >= NUM_CH);
      end
   end

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] active;
      logic [WIDTH-1:0] shadow;
      logic             pend;
      logic             clk_q;
      logic             tick_q;
      logic             load_hit;

      assign load_hit     = load_i && (int'(ch_i) == n);
      assign clk_o[n]     = clk_q;
      assign tick_o[n]    = tick_q;
      assign pending_o[n] = pend;

      // Channel state. A stopped channel (active == 0) picks up any pending
      // value on the next edge even when disabled, so a restart does not
      // depend on en_i. A running channel only swaps in the shadow value at
      // its terminal count. The load capture is written last so that a load
      // landing on a boundary edge is kept pending for the following one,
      // while the boundary itself consumes the previous shadow value.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cnt    <= '0;
            active <= WIDTH'(DEFAULT_HALF);
            shadow <= WIDTH'(DEFAULT_HALF);
            pend   <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            tick_q <= 1'b0;
            if (active == '0) begin
               cnt   <= '0;
               clk_q <= 1'b0;
               if (pend) begin
                  active <= shadow;
                  pend   <= 1'b0;
               end
            end else if (en_i[n]) begin
               if (cnt >= active - WIDTH'(1)) begin
                  cnt    <= '0;
                  tick_q <= 1'b1;
                  if (pend) begin
                     active <= shadow;
                     pend   <= 1'b0;
                     clk_q  <= (shadow != '0) ? ~clk_q : 1'b0;
                  end else begin
                     clk_q <= ~clk_q;
                  end
               end else begin
                  cnt <= cnt + WIDTH'(1);
               end
            end
            if (load_hit) begin
               shadow <= half_i;
               pend   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank. A four-channel instance (half-period 3 after
// reset) is checked every cycle against a countdown model of each divider,
// plus directed checks with hand-computed values. A three-channel instance
// covers loads addressed past the last channel.
module tb_clk_div_bank;

   localparam int NUM = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] en;
   logic       load;
   logic [1:0] ch;
   logic [7:0] half;
   logic [3:0] clkO;
   logic [3:0] tickO;
   logic [3:0] pendO;
   logic       loadErr;

   logic [2:0] enB;
   logic       loadB;
   logic [1:0] chB;
   logic [7:0] halfB;
   logic [2:0] clkB;
   logic [2:0] tickB;
   logic [2:0] pendB;
   logic       loadErrB;

   int vectors     = 0;
   int miscompares = 0;

   // Model state: half-period in use, waiting value, cycles left to boundary.
   int  mHalf[NUM];
   int  mShadow[NUM];
   int  mRemain[NUM];
   bit  mPend[NUM];
   bit  mLevel[NUM];
   bit  mTick[NUM];
   bit  mErr;
   bit  modelValid = 1'b0;
   logic [3:0] eClk;
   logic [3:0] eTick;
   logic [3:0] ePend;

   always #5 clk = ~clk;

   clk_div_bank #(
      .NUM_CH(4), .WIDTH(8), .DEFAULT_HALF(3)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .ch_i(ch),
      .half_i(half), .clk_o(clkO), .tick_o(tickO), .pending_o(pendO),
      .load_err_o(loadErr)
   );

   clk_div_bank #(
      .NUM_CH(3), .WIDTH(8), .DEFAULT_HALF(3)
   ) dutB (
      .clk_i(clk), .rst_i(rst), .en_i(enB), .load_i(loadB), .ch_i(chB),
      .half_i(halfB), .clk_o(clkB), .tick_o(tickB), .pending_o(pendB),
      .load_err_o(loadErrB)
   );

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge with the given inputs; returns at the following negedge.
   task automatic applyStimulus(input logic [3:0] e, input logic ld,
                                input logic [1:0] c, input logic [7:0] h);
      en   = e;
      load = ld;
      ch   = c;
      half = h;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
   endtask

   // Each channel counts down the cycles to its next boundary; at a boundary
   // it toggles, strobes, and adopts a waiting value. Loads seen at an edge
   // are recorded after that edge's boundary decision.
   always @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NUM; n++) begin
            mHalf[n]   = 3;
            mShadow[n] = 3;
            mRemain[n] = 3;
            mPend[n]   = 1'b0;
            mLevel[n]  = 1'b0;
            mTick[n]   = 1'b0;
         end
         mErr = 1'b0;
      end else begin
         for (int n = 0; n < NUM; n++) begin
            mTick[n] = 1'b0;
            if (mHalf[n] == 0) begin
               mLevel[n] = 1'b0;
               if (mPend[n]) begin
                  mHalf[n]   = mShadow[n];
                  mPend[n]   = 1'b0;
                  mRemain[n] = mHalf[n];
               end
            end else if (en[n]) begin
               mRemain[n] = mRemain[n] - 1;
               if (mRemain[n] == 0) begin
                  mTick[n] = 1'b1;
                  if (mPend[n]) begin
                     mHalf[n]  = mShadow[n];
                     mPend[n]  = 1'b0;
                     mLevel[n] = (mHalf[n] != 0) ? !mLevel[n] : 1'b0;
                  end else begin
                     mLevel[n] = !mLevel[n];
                  end
                  mRemain[n] = mHalf[n];
               end
            end
            if (load && int'(ch) == n) begin
               mShadow[n] = int'(half);
               mPend[n]   = 1'b1;
            end
         end
         mErr = load && (int'(ch) >= NUM);
      end
      modelValid = 1'b1;
   end

   // Every-cycle comparison of the four-channel instance against the model.
   always @(negedge clk) begin
      if (modelValid) begin
         for (int n = 0; n < NUM; n++) begin
            eClk[n]  = mLevel[n];
            eTick[n] = mTick[n];
            ePend[n] = mPend[n];
         end
         checkOutput("model_clk_o", 32'(clkO), 32'(eClk));
         checkOutput("model_tick_o", 32'(tickO), 32'(eTick));
         checkOutput("model_pending_o", 32'(pendO), 32'(ePend));
         checkOutput("model_load_err_o", 32'(loadErr), 32'(mErr));
      end
   end

   initial begin
      rst   = 1'b1;
      en    = 4'hF;
      load  = 1'b0;
      ch    = 2'd0;
      half  = 8'd0;
      enB   = 3'b111;
      loadB = 1'b0;
      chB   = 2'd0;
      halfB = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_clk_o", 32'(clkO), 32'h0);
      checkOutput("reset_tick_o", 32'(tickO), 32'h0);
      checkOutput("reset_pending_o", 32'(pendO), 32'h0);
      checkOutput("reset_load_err_o", 32'(loadErr), 32'h0);
      checkOutput("reset_load_err_b", 32'(loadErrB), 32'h0);
      rst = 1'b0;

      // Default half-period 3 on every channel.
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e2_clk_o", 32'(clkO), 32'h0);
      checkOutput("e2_tick_o", 32'(tickO), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e3_clk_o", 32'(clkO), 32'hF);
      checkOutput("e3_tick_o", 32'(tickO), 32'hF);
      checkOutput("e3_clk_b", 32'(clkB), 32'h7);
      checkOutput("e3_tick_b", 32'(tickB), 32'h7);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e6_clk_o", 32'(clkO), 32'h0);
      checkOutput("e6_tick_o", 32'(tickO), 32'hF);

      // Mid-period load of half-period 1 into channel 1.
      applyStimulus(4'hF, 1'b1, 2'd1, 8'd1);
      checkOutput("e7_pending_o", 32'(pendO), 32'h2);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e8_pending_o", 32'(pendO), 32'h2);
      checkOutput("e8_clk_o", 32'(clkO), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e9_pending_o", 32'(pendO), 32'h0);
      checkOutput("e9_clk_o", 32'(clkO), 32'hF);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e10_clk_o", 32'(clkO), 32'hD);
      checkOutput("e10_tick_o", 32'(tickO), 32'h2);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e11_clk_o", 32'(clkO), 32'hF);
      checkOutput("e11_tick_o", 32'(tickO), 32'h2);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e12_clk_o", 32'(clkO), 32'h0);
      checkOutput("e12_tick_o", 32'(tickO), 32'hF);

      // Load 5 into channel 0 on the same edge as its boundary.
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b1, 2'd0, 8'd5);
      checkOutput("e15_clk0", 32'(clkO[0]), 32'h1);
      checkOutput("e15_tick0", 32'(tickO[0]), 32'h1);
      checkOutput("e15_pending_o", 32'(pendO), 32'h1);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e18_clk0", 32'(clkO[0]), 32'h0);
      checkOutput("e18_tick0", 32'(tickO[0]), 32'h1);
      checkOutput("e18_pending_o", 32'(pendO), 32'h0);
      checkOutput("e18_model_half0", 32'(mHalf[0]), 32'd5);
      repeat (4) applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e22_clk0", 32'(clkO[0]), 32'h0);
      checkOutput("e22_tick0", 32'(tickO[0]), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e23_clk0", 32'(clkO[0]), 32'h1);
      checkOutput("e23_tick0", 32'(tickO[0]), 32'h1);

      // Hold channel 2 for four edges with its count at 1.
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e25_clk2", 32'(clkO[2]), 32'h0);
      repeat (4) applyStimulus(4'b1011, 1'b0, 2'd0, 8'd0);
      checkOutput("e29_clk2", 32'(clkO[2]), 32'h0);
      checkOutput("e29_tick2", 32'(tickO[2]), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e30_clk2", 32'(clkO[2]), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e31_clk2", 32'(clkO[2]), 32'h1);
      checkOutput("e31_tick2", 32'(tickO[2]), 32'h1);

      // Stop channel 3 with a zero load, then restart it with 2.
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e33_clk3", 32'(clkO[3]), 32'h1);
      applyStimulus(4'hF, 1'b1, 2'd3, 8'd0);
      checkOutput("e34_pend3", 32'(pendO[3]), 32'h1);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e36_clk3", 32'(clkO[3]), 32'h0);
      checkOutput("e36_tick3", 32'(tickO[3]), 32'h1);
      checkOutput("e36_pend3", 32'(pendO[3]), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e38_clk3", 32'(clkO[3]), 32'h0);
      checkOutput("e38_tick3", 32'(tickO[3]), 32'h0);
      applyStimulus(4'hF, 1'b1, 2'd3, 8'd2);
      checkOutput("e39_pend3", 32'(pendO[3]), 32'h1);
      checkOutput("e39_clk3", 32'(clkO[3]), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e40_pend3", 32'(pendO[3]), 32'h0);
      checkOutput("e40_clk3", 32'(clkO[3]), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e41_clk3", 32'(clkO[3]), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("e42_clk3", 32'(clkO[3]), 32'h1);
      checkOutput("e42_tick3", 32'(tickO[3]), 32'h1);

      // Back-to-back loads to channel 1; only the last value survives.
      applyStimulus(4'hF, 1'b1, 2'd1, 8'd2);
      applyStimulus(4'hF, 1'b1, 2'd1, 8'd4);
      applyStimulus(4'hF, 1'b1, 2'd1, 8'd3);

      // Three-channel instance: a load to channel 3 is rejected.
      loadB = 1'b1;
      chB   = 2'd3;
      halfB = 8'd5;
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      loadB = 1'b0;
      checkOutput("bad_load_err", 32'(loadErrB), 32'h1);
      checkOutput("bad_load_pending", 32'(pendB), 32'h0);
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      checkOutput("bad_load_err_clear", 32'(loadErrB), 32'h0);
      checkOutput("bad_load_pending_after", 32'(pendB), 32'h0);
      loadB = 1'b1;
      chB   = 2'd2;
      halfB = 8'd4;
      applyStimulus(4'hF, 1'b0, 2'd0, 8'd0);
      loadB = 1'b0;
      checkOutput("good_load_err", 32'(loadErrB), 32'h0);

      // Mixed loads and enables, checked by the model alone.
      for (int i = 0; i < 90; i++) begin
         applyStimulus((i % 11 < 3) ? 4'b0110 : 4'hF, (i % 7) == 0,
                       2'(i % 4), 8'((i % 5) + ((i % 3 == 0) ? 0 : 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
